// File: rtl/amdf_pitch_detector_if.sv
// Sample stream in, pitch result out, for the AMDF pitch detector.
// master drives samples and observes results; slave is the detector.
interface amdf_pitch_detector_if;
   logic signed [15:0] sample_in;
   logic               sample_valid_in;
   logic [10:0]        tau_out;
   logic               tau_valid_out;
   logic               busy_out;
   logic               overrun_out;

   modport master (
      output sample_in, sample_valid_in,
      input  tau_out, tau_valid_out, busy_out, overrun_out
   );

   modport slave (
      input  sample_in, sample_valid_in,
      output tau_out, tau_valid_out, busy_out, overrun_out
   );
endinterface

// File: rtl/amdf_pitch_detector.sv
// AMDF pitch detector: ping-pong windows, min-D lag search per window.
// Ports: clk_in, rst_in (async, active-low), bus (sample in, tau/busy/overrun out).
module amdf_pitch_detector #(
   parameter int WINDOW_SIZE = 2048,
   parameter int TAU_MIN     = 32,
   parameter int TAU_MAX     = 1023
) (
   input  logic                 clk_in,
   input  logic                 rst_in,
   amdf_pitch_detector_if.slave bus
);
   localparam int SUM_LEN = WINDOW_SIZE - TAU_MAX;
   localparam int CW      = $clog2(WINDOW_SIZE);
   localparam logic [10:0]   TMIN  = 11'(TAU_MIN);
   localparam logic [10:0]   TMAX  = 11'(TAU_MAX);
   localparam logic [CW-1:0] NLAST = CW'(SUM_LEN - 1);

   typedef enum logic [2:0] {IDLE, ACCUM, DRAIN, COMPARE, DONE} state_t;

   state_t state;

   logic [CW-1:0] count;
   logic          bank;
   logic          wdone;
   logic          wbank;

   logic          abank;
   logic [CW-1:0] n;
   logic [10:0]   t;
   logic [1:0]    dcnt;
   logic [31:0]   best_d;
   logic [10:0]   best_t;
   logic [10:0]   tau_q;
   logic          tau_v;
   logic          ovr;

   logic signed [15:0] mem0 [2*WINDOW_SIZE];
   logic signed [15:0] mem1 [2*WINDOW_SIZE];
   logic signed [15:0] rd0_a, rd0_b, rd1_a, rd1_b;
   logic [CW:0]        ra0, ra1;
   logic [CW-1:0]      off;
   logic signed [16:0] diff;
   logic [15:0]        ab;
   logic               v1, v2, v3;
   logic [31:0]        acc;
   logic               clr;

   // Window fill; window_done is registered, tagged with the bank just filled.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         count <= '0;
         bank  <= 1'b0;
         wdone <= 1'b0;
         wbank <= 1'b0;
      end else begin
         wdone <= 1'b0;
         if (bus.sample_valid_in) begin
            count <= count + CW'(1);
            if (count == CW'(WINDOW_SIZE - 1)) begin
               bank  <= ~bank;
               wdone <= 1'b1;
               wbank <= bank;
            end
         end
      end
   end

   // Both copies share the write; each copy serves one read stream.
   assign off = n + CW'(t);
   assign ra0 = {abank, n};
   assign ra1 = {abank, off};

   always_ff @(posedge clk_in) begin
      if (bus.sample_valid_in) begin
         mem0[{bank, count}] <= bus.sample_in;
         mem1[{bank, count}] <= bus.sample_in;
      end
      rd0_a <= mem0[ra0];
      rd1_a <= mem1[ra1];
      rd0_b <= rd0_a;
      rd1_b <= rd1_a;
      ab    <= diff[16] ? 16'(-diff) : diff[15:0];
   end

   assign diff = {rd0_b[15], rd0_b} - {rd1_b[15], rd1_b};

   // Accumulator is zero whenever a lag starts; a new window also
   // flushes terms still in flight from the aborted lag.
   assign clr = wdone || (state != ACCUM && state != DRAIN);

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         v1  <= 1'b0;
         v2  <= 1'b0;
         v3  <= 1'b0;
         acc <= '0;
      end else begin
         v1 <= (state == ACCUM) && !wdone;
         v2 <= v1 && !wdone;
         v3 <= v2 && !wdone;
         if (clr)
            acc <= '0;
         else if (v3)
            acc <= acc + 32'(ab);
      end
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state  <= IDLE;
         abank  <= 1'b0;
         n      <= '0;
         t      <= TMIN;
         dcnt   <= '0;
         best_d <= '1;
         best_t <= TMIN;
         tau_q  <= '0;
         tau_v  <= 1'b0;
         ovr    <= 1'b0;
      end else begin
         tau_v <= 1'b0;
         ovr   <= 1'b0;
         if (state == DONE) begin
            tau_q <= best_t;
            tau_v <= 1'b1;
         end
         if (wdone) begin
            ovr    <= (state != IDLE) && (state != DONE);
            state  <= ACCUM;
            abank  <= wbank;
            n      <= '0;
            t      <= TMIN;
            best_d <= '1;
            best_t <= TMIN;
         end else begin
            unique case (state)
               IDLE: ;
               ACCUM: begin
                  if (n == NLAST) begin
                     state <= DRAIN;
                     dcnt  <= '0;
                  end else begin
                     n <= n + CW'(1);
                  end
               end
               DRAIN: begin
                  dcnt <= dcnt + 2'd1;
                  if (dcnt == 2'd3)
                     state <= COMPARE;
               end
               COMPARE: begin
                  if (acc < best_d) begin
                     best_d <= acc;
                     best_t <= t;
                  end
                  if (t == TMAX) begin
                     state <= DONE;
                  end else begin
                     t     <= t + 11'd1;
                     n     <= '0;
                     state <= ACCUM;
                  end
               end
               DONE: state <= IDLE;
               default: state <= IDLE;
            endcase
         end
      end
   end

   assign bus.tau_out       = tau_q;
   assign bus.tau_valid_out = tau_v;
   assign bus.overrun_out   = ovr;
   assign bus.busy_out      = (state != IDLE);
endmodule

// File: tb/tb_amdf_pitch_detector.sv
// Scoreboard bench for amdf_pitch_detector (WINDOW_SIZE=64, lags 4..31).
// Stimulus pushes expected tau/cycle; a negedge monitor pops and compares.
module tb_amdf_pitch_detector;
   localparam int LAT = 28 * 38 + 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   amdf_pitch_detector_if bus ();

   amdf_pitch_detector #(
      .WINDOW_SIZE(64),
      .TAU_MIN(4),
      .TAU_MAX(31)
   ) dut (
      .clk_in(clk),
      .rst_in(rst_n),
      .bus(bus)
   );

   typedef struct {
      int tau;
      int when;
   } exp_t;

   exp_t sb[$];
   int checks = 0;
   int fails = 0;
   int ovr_seen = 0;
   int last_cyc = 0;

   task automatic check(string name, int act, int exp);
      checks++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic send(int s);
      bus.sample_in = 16'(s);
      bus.sample_valid_in = 1'b1;
      @(negedge clk);
      bus.sample_valid_in = 1'b0;
      last_cyc = cyc;
   endtask

   task automatic send_gapped(int s);
      while ($urandom_range(2) != 0) @(negedge clk);
      send(s);
   endtask

   task automatic expect_tau(int tau);
      exp_t e;
      e.tau = tau;
      e.when = last_cyc + LAT;
      sb.push_back(e);
   endtask

   task automatic wait_empty();
      for (int i = 0; i < 3000 && sb.size() != 0; i++) @(negedge clk);
      checks++;
      if (sb.size() != 0) begin
         fails++;
         $display("FAIL timeout: %0d results pending, expected 0", sb.size());
         sb.delete();
      end
   endtask

   task automatic idle(int k);
      for (int i = 0; i < k; i++) @(negedge clk);
   endtask

   function automatic int sq(int n, int p);
      return ((n % p) < (p / 2)) ? 1000 : -1000;
   endfunction

   function automatic int imp17(int n);
      if (n % 17 == 0) return -32768;
      if (n % 17 == 8) return 32767;
      return 0;
   endfunction

   function automatic int sine23(int n);
      real ph;
      ph = 6.283185307179586 * real'(n % 23) / 23.0;
      return $rtoi(8000.0 * $sin(ph));
   endfunction

   always @(negedge clk) begin
      exp_t e;
      if (rst_n) begin
         if (bus.overrun_out) ovr_seen++;
         if (bus.tau_valid_out) begin
            if (sb.size() == 0) begin
               checks++;
               fails++;
               $display("FAIL unexpected_tau: got %0d, expected none",
                        bus.tau_out);
            end else begin
               e = sb.pop_front();
               check("tau", int'(bus.tau_out), e.tau);
               check("latency", cyc, e.when);
            end
         end
      end
   end

   initial begin
      bus.sample_in = '0;
      bus.sample_valid_in = 1'b0;
      #2;
      check("rst_tau", int'(bus.tau_out), 0);
      check("rst_valid", int'(bus.tau_valid_out), 0);
      check("rst_busy", int'(bus.busy_out), 0);
      check("rst_ovr", int'(bus.overrun_out), 0);
      idle(2);
      rst_n = 1'b1;
      idle(2);

      // T1: square period 10
      for (int n = 0; n < 64; n++) send(sq(n, 10));
      expect_tau(10);
      idle(5);
      check("busy", int'(bus.busy_out), 1);
      wait_empty();

      // T2: all zero, tie resolves to TAU_MIN
      for (int n = 0; n < 64; n++) send(0);
      expect_tau(4);
      wait_empty();

      // T3: full-scale impulses, period 17
      for (int n = 0; n < 64; n++) send(imp17(n));
      expect_tau(17);
      wait_empty();

      // T4: second window lands 500 cycles into the first analysis
      for (int n = 0; n < 64; n++) send(sq(n, 10));
      idle(436);
      for (int n = 0; n < 64; n++) send(sq(n, 12));
      expect_tau(12);
      wait_empty();
      check("overrun_t4", ovr_seen, 1);

      // T5: reset mid-analysis
      for (int n = 0; n < 64; n++) send(sq(n, 10));
      idle(300);
      #2;
      rst_n = 1'b0;
      #1;
      check("rst5_tau", int'(bus.tau_out), 0);
      check("rst5_valid", int'(bus.tau_valid_out), 0);
      check("rst5_busy", int'(bus.busy_out), 0);
      check("rst5_ovr", int'(bus.overrun_out), 0);
      @(negedge clk);
      rst_n = 1'b1;
      idle(2);
      for (int n = 0; n < 64; n++) send(sq(n, 7));
      expect_tau(7);
      wait_empty();

      // T6: gapped sine, period 23
      for (int n = 0; n < 64; n++) send_gapped(sine23(n));
      expect_tau(23);
      wait_empty();
      idle(10);
      check("overrun_total", ovr_seen, 1);

      $display("End of test - %0d assertions evaluated, %0d failures",
               checks, fails);
      $finish;
   end
endmodule
